// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types for the reservation-station scheduler: core sizing, the renamed
// uop payload carried through the station, and the writeback tag-match helper.
package rs_issue_scheduler_pkg;

  localparam int RS_ENTRIES   = 8;
  localparam int DISP_WIDTH   = 2;
  localparam int NUM_FUS      = 4;
  localparam int NUM_PREGS    = 128;
  localparam int NUM_ROB_ENTS = 64;
  localparam int PW           = $clog2(NUM_PREGS);
  localparam int RW           = $clog2(NUM_ROB_ENTS);
  localparam int RS_IW        = $clog2(RS_ENTRIES);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_MUL, OP_LD, OP_ST
  } instr_opcode;

  typedef struct packed {
    logic [PW-1:0] dst_preg;
    logic [PW-1:0] src1_reg;
    logic [PW-1:0] src2_reg;
    logic          src1_en;
    logic          src2_en;
    logic [31:0]   imm_val;
    instr_opcode   opcode;
    logic [RW-1:0] rob_index;
  } Rs_uOP;

  typedef logic [NUM_FUS-1:0][PW-1:0] wb_tags_t;

  // True when any valid writeback port broadcasts this physical register.
  function automatic logic tag_hit(input logic [PW-1:0]      tag,
                                   input logic [NUM_FUS-1:0] wb_valid,
                                   input wb_tags_t           wb_preg);
    tag_hit = 1'b0;
    for (int k = 0; k < NUM_FUS; k++) begin
      if (wb_valid[k] && (wb_preg[k] == tag)) tag_hit = 1'b1;
    end
  endfunction

endpackage

// File: rtl/rs_issue_scheduler_if.sv
// Dispatch, writeback-broadcast and issue bundle of one scheduler instance.
// The slave side is the scheduler; the master side is dispatch/FU/testbench.
interface rs_issue_scheduler_if;
  import rs_issue_scheduler_pkg::*;

  logic [DISP_WIDTH-1:0]        disp_valid;
  Rs_uOP [DISP_WIDTH-1:0]       disp_uop;
  logic                         disp_ready;
  logic [NUM_FUS-1:0]           wb_valid;
  wb_tags_t                     wb_preg;
  logic                         iss_valid;
  logic                         iss_ready;
  Rs_uOP                        iss_uop;
  logic [RS_IW-1:0]             iss_rs_index;
  logic [RS_IW:0]               occupancy;

  modport master (
    output disp_valid, disp_uop, wb_valid, wb_preg, iss_ready,
    input  disp_ready, iss_valid, iss_uop, iss_rs_index, occupancy
  );

  modport slave (
    input  disp_valid, disp_uop, wb_valid, wb_preg, iss_ready,
    output disp_ready, iss_valid, iss_uop, iss_rs_index, occupancy
  );
endinterface

// File: rtl/rs_oldest_pick.sv
// Combinational oldest-ready selector over an age matrix where age[i][j]=1
// means entry j is older than entry i.
module rs_oldest_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]        ready,
  input  logic [N-1:0][N-1:0] age,
  output logic [N-1:0]        grant,
  output logic [IW-1:0]       idx,
  output logic                any
);
  genvar gi;

  // An entry wins when no other ready entry is older than it.
  generate
    for (gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = ready[gi] & ~(|(ready & age[gi]));
    end
  endgenerate

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) idx = IW'(i);
    end
  end

  assign any = |ready;
endmodule

// File: rtl/rs_issue_scheduler.sv
// Single-pipe reservation station: all-or-nothing dispatch into the lowest free
// slots, tag-broadcast wakeup, and oldest-ready issue through an age matrix.
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  rs_issue_scheduler_if.slave  bus
);
  genvar gi;

  logic [RS_ENTRIES-1:0]                  valid_vec;
  logic [RS_ENTRIES-1:0]                  rdy1_vec;
  logic [RS_ENTRIES-1:0]                  rdy2_vec;
  logic [RS_ENTRIES-1:0]                  ready_vec;
  logic [RS_ENTRIES-1:0]                  grant;
  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0]  age_mat;
  Rs_uOP                                  uop_arr [RS_ENTRIES];
  logic [RS_IW:0]                         occ_reg;
  logic [RS_IW-1:0]                       pick_idx;
  logic                                   pick_any;
  logic                                   disp_ready;
  logic                                   disp_fire;
  logic                                   issue_fire;
  logic [RS_IW-1:0]                       free_idx [DISP_WIDTH];
  logic [RS_IW-1:0]                       slot_idx [DISP_WIDTH];
  logic [DISP_WIDTH-1:0]                  slot_we;
  logic [RS_ENTRIES-1:0]                  slot_older [DISP_WIDTH];
  logic [RS_ENTRIES-1:0]                  new_alloc;
  logic [RS_IW:0]                         disp_cnt;

  // Free count uses registered occupancy only, so a slot vacated by this
  // cycle's issue is not offered to dispatch until next cycle.
  assign disp_ready = (occ_reg <= (RS_IW+1)'(RS_ENTRIES - DISP_WIDTH));
  assign disp_fire  = disp_ready & ~flush;
  assign ready_vec  = valid_vec & rdy1_vec & rdy2_vec;
  assign issue_fire = pick_any & bus.iss_ready;

  // k-th lowest free entry, for k below DISP_WIDTH.
  always_comb begin
    int n;
    n = 0;
    for (int k = 0; k < DISP_WIDTH; k++) free_idx[k] = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (!valid_vec[i]) begin
        for (int k = 0; k < DISP_WIDTH; k++) begin
          if (n == k) free_idx[k] = RS_IW'(i);
        end
        n = n + 1;
      end
    end
  end

  // Each valid slot takes the free entry ranked by how many valid slots precede it.
  always_comb begin
    int rank;
    rank      = 0;
    new_alloc = '0;
    disp_cnt  = '0;
    for (int s = 0; s < DISP_WIDTH; s++) begin
      slot_idx[s] = '0;
      for (int k = 0; k < DISP_WIDTH; k++) begin
        if (rank == k) slot_idx[s] = free_idx[k];
      end
      slot_older[s] = new_alloc;
      slot_we[s]    = disp_fire & bus.disp_valid[s];
      if (bus.disp_valid[s]) rank = rank + 1;
      if (slot_we[s]) begin
        new_alloc[slot_idx[s]] = 1'b1;
        disp_cnt               = disp_cnt + 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < RS_ENTRIES; gi++) begin : g_entry
      logic                  valid_reg;
      logic                  rdy1_reg;
      logic                  rdy2_reg;
      logic [RS_ENTRIES-1:0] age_reg;
      Rs_uOP                 uop_reg;
      logic                  alloc_hit;
      Rs_uOP                 alloc_uop;
      logic [RS_ENTRIES-1:0] alloc_row;

      always_comb begin
        alloc_hit = 1'b0;
        alloc_uop = '0;
        alloc_row = '0;
        for (int s = 0; s < DISP_WIDTH; s++) begin
          if (slot_we[s] && (slot_idx[s] == RS_IW'(gi))) begin
            alloc_hit = 1'b1;
            alloc_uop = bus.disp_uop[s];
            alloc_row = valid_vec | slot_older[s];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          rdy1_reg  <= 1'b0;
          rdy2_reg  <= 1'b0;
          age_reg   <= '0;
        end else if (flush) begin
          valid_reg <= 1'b0;
          age_reg   <= '0;
        end else if (alloc_hit) begin
          valid_reg <= 1'b1;
          rdy1_reg  <= ~alloc_uop.src1_en |
                       tag_hit(alloc_uop.src1_reg, bus.wb_valid, bus.wb_preg);
          rdy2_reg  <= ~alloc_uop.src2_en |
                       tag_hit(alloc_uop.src2_reg, bus.wb_valid, bus.wb_preg);
          age_reg   <= alloc_row;
        end else begin
          if (issue_fire && grant[gi]) valid_reg <= 1'b0;
          rdy1_reg <= rdy1_reg | tag_hit(uop_reg.src1_reg, bus.wb_valid, bus.wb_preg);
          rdy2_reg <= rdy2_reg | tag_hit(uop_reg.src2_reg, bus.wb_valid, bus.wb_preg);
          // Newcomers are younger than everyone already here.
          age_reg  <= age_reg & ~new_alloc;
        end
      end

      // Payload needs no reset: it is only observed while valid_reg is set.
      always_ff @(posedge clk) begin
        if (alloc_hit) uop_reg <= alloc_uop;
      end

      assign valid_vec[gi] = valid_reg;
      assign rdy1_vec[gi]  = rdy1_reg;
      assign rdy2_vec[gi]  = rdy2_reg;
      assign age_mat[gi]   = age_reg;
      assign uop_arr[gi]   = uop_reg;
    end
  endgenerate

  rs_oldest_pick #(.N(RS_ENTRIES)) u_pick (
    .ready (ready_vec),
    .age   (age_mat),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_reg <= '0;
    end else if (flush) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_reg + disp_cnt - (RS_IW+1)'(issue_fire);
    end
  end

  assign bus.disp_ready   = disp_ready;
  assign bus.iss_valid    = pick_any;
  assign bus.iss_uop      = uop_arr[pick_idx];
  assign bus.iss_rs_index = pick_idx;
  assign bus.occupancy    = occ_reg;
endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
Single-pipe reservation-station scheduler sitting between dispatch and one execution pipe (ALU_LOWER, ALU_UPPER, MUL or LSU; one instance per pipe). Holds up to RS_ENTRIES renamed uops and tracks source-operand readiness from writeback tag broadcasts. Issues the oldest ready uop each cycle to its functional unit, and clears all entries on a pipeline flush.

Parameters:
RS_ENTRIES, 8, entry count; power of two, at least 4
DISP_WIDTH, 2, dispatch slots per cycle
NUM_FUS, 4, writeback tag broadcast ports
NUM_PREGS, 128, physical registers; tag width PW = $clog2(NUM_PREGS)
NUM_ROB_ENTS, 64, ROB size; index width RW = $clog2(NUM_ROB_ENTS)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
flush  in  1  mispredict or exception flush; clears all entries
disp_valid  in  DISP_WIDTH  per-slot dispatch request
disp_uop  in  DISP_WIDTH x Rs_uOP  dispatch payload; fields: dst_preg, src1_reg, src2_reg, src1_en, src2_en, imm_val[31:0], opcode, rob_index
disp_ready  out  1  both slots may be accepted this cycle
wb_valid  in  NUM_FUS  tag broadcast valid
wb_preg  in  NUM_FUS x PW  broadcast destination tags
iss_valid  out  1  a ready uop is presented
iss_ready  in  1  functional unit accepts this cycle
iss_uop  out  Rs_uOP  selected payload
iss_rs_index  out  $clog2(RS_ENTRIES)  slot of the issued entry
occupancy  out  $clog2(RS_ENTRIES)+1  valid entry count

Behaviour:
- Reset (async, rst=1): all entry valid bits = 0, age matrix = 0, occupancy = 0, iss_valid = 0, disp_ready = 1. iss_uop and iss_rs_index are don't-care while iss_valid = 0.
- Per-entry state: valid, src1_rdy, src2_rdy, payload. The age matrix holds age[i][j] = 1 when entry j is older than entry i.
- disp_ready = (free entries >= DISP_WIDTH), computed from registered state only. An entry freed by issue this cycle does not count toward disp_ready.
- Dispatch is all-or-nothing. When disp_ready = 1, every valid slot is written at the clock edge.
  - Slot 0 takes the lowest free index; slot 1 takes the next lowest.
  - If only slot 1 is valid, it takes the lowest free index.
  - disp_valid while disp_ready = 0 is ignored; the upstream stage holds its payload.
- Allocation of entry i: row i = current valid vector. For slot 1, also set the bit for slot 0's new entry. Column i is cleared in all rows.
- Initial readiness: src_rdy = ~src_en | (src tag matches any wb_valid/wb_preg pair in the same cycle).
- Wakeup: every cycle, a valid entry sets srcN_rdy when srcN_reg == wb_preg[k] with wb_valid[k], for any k. Ready bits are registered, so a woken entry is eligible for selection in the following cycle.
- Select (combinational from registered state):
  - ready_i = valid_i & src1_rdy_i & src2_rdy_i.
  - Pick entry i with ready_i and no j where ready_j & age[i][j].
  - iss_valid = |ready; iss_uop and iss_rs_index come from the picked entry.
  - The selection may change between cycles while iss_ready = 0; the FU samples the payload only on handshake.
- Issue: when iss_valid & iss_ready, the picked entry's valid bit clears at the edge. At most one issue per cycle.
- Simultaneous issue and dispatch: both take effect. Occupancy next = occupancy + dispatched - issued.
- Flush: at the edge, all valid bits and the age matrix clear and occupancy = 0.
  - Flush wins over same-cycle dispatch and issue; dispatched uops are dropped.
  - iss_valid is not gated by flush in that cycle, so the FU must itself drop a uop handshaked during flush.
- Occupancy never exceeds RS_ENTRIES; overflow cannot occur because of the all-or-nothing disp_ready rule.
- Reset asserted mid-operation: same as the reset state; all uops are lost silently.

Decomposition:
- CORE_PKG gains the Rs_uOP packed struct (fields listed under Ports) and reuses RS_ENTRIES, NUM_PREGS, NUM_ROB_ENTS, NUM_FUS, DISP_WIDTH and instr_opcode.
- Sub-module rs_oldest_pick: purely combinational. Inputs: ready vector and age matrix. Outputs: one-hot grant, encoded index, any-ready. It is reused by the other pipe instances and by the LSU queue.

Test Plan:
- Reset, then dispatch uop A (src1_en=0, src2_en=0, rob_index 5) with iss_ready=1 -> iss_valid=1 on the next cycle with rob_index 5; occupancy goes 1 then 0.
- Dispatch A (src1=p20) then B (src1=p21) with iss_ready=1; broadcast p21 at cycle 3 and p20 at cycle 4 -> B issues at cycle 4, A at cycle 5 (wakeup order, not age).
- Fill 8 entries, all waiting on p40 -> disp_ready=0 at 7 and at 8 entries. Broadcast p40 with iss_ready=1 -> issue in dispatch order, rob_index 0..7, one per cycle.
- Same-cycle dispatch of C (src2=p33) and wb_valid[2]=1, wb_preg[2]=33 -> C issues the following cycle; the tag is not missed.
- Six entries valid, with flush, dispatch and iss_ready all asserted in one cycle -> occupancy=0, disp_ready=1, iss_valid=0 on the next cycle.
- Two entries ready (older X, younger Y) with iss_ready=0 for 3 cycles, then 1 -> X issues first, then Y; no loss or duplication.
